bus_sequencer: RTL and testbench

- Initiator side of the shared unit bus; drives `write_id`, `read_id`, `write_command` and `read_command` into the bus top in place of hand-driven test ports.
- Accepts queued transfer requests (source unit/command, destination unit/command) and issues them one at a time.
- Waits for the source unit's valid, captures the transferred word and reports done, or reports timeout.
- Sits between the future control unit and the bus top.

---
 rtl/bus_sequencer_if.sv | 36 +++
 rtl/bus_sequencer.sv | 177 +++++++++++++++++
 tb/tb_bus_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sequencer_if.sv
// Request-side and bus-side signal bundle of bus_sequencer.
// The master modport is the sequencer's view; the slave modport is the control unit / bus top view.
interface bus_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic [3:0]        i_req_write_id;
    logic [3:0]        i_req_write_cmd;
    logic [3:0]        i_req_read_id;
    logic [3:0]        i_req_read_cmd;
    logic [3:0]        o_write_id;
    logic [3:0]        o_write_command;
    logic [3:0]        o_read_id;
    logic [3:0]        o_read_command;
    logic              i_bus_valid;
    logic [DATA_W-1:0] i_bus_data;
    logic              o_done;
    logic              o_error;
    logic [DATA_W-1:0] o_data;
    logic              o_busy;

    modport master (
        input  i_req_valid, i_req_write_id, i_req_write_cmd, i_req_read_id, i_req_read_cmd,
        input  i_bus_valid, i_bus_data,
        output o_req_ready, o_write_id, o_write_command, o_read_id, o_read_command,
        output o_done, o_error, o_data, o_busy
    );

    modport slave (
        output i_req_valid, i_req_write_id, i_req_write_cmd, i_req_read_id, i_req_read_cmd,
        output i_bus_valid, i_bus_data,
        input  o_req_ready, o_write_id, o_write_command, o_read_id, o_read_command,
        input  o_done, o_error, o_data, o_busy
    );
endinterface

// File: rtl/bus_sequencer.sv
// Bus initiator: queues transfer requests, issues them one at a time and reports done or timeout.
// Optional BUS_SEQ_STATS_EN adds saturating done/error event counters.
module bus_sequencer #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    bus_sequencer_if.master bus
`ifdef BUS_SEQ_STATS_EN
    ,
    output logic [15:0]     o_done_count,
    output logic [15:0]     o_error_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [3:0] write_id;
        logic [3:0] write_cmd;
        logic [3:0] read_id;
        logic [3:0] read_cmd;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RECOVER
    } state_t;

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    req_t             req_in;
    req_t             head;

    state_t            state_q, state_d;
    req_t              ids_q, ids_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A full FIFO refuses a push even on an edge that also pops.
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign push   = bus.i_req_valid && !full;
    assign req_in = '{write_id:  bus.i_req_write_id,
                      write_cmd: bus.i_req_write_cmd,
                      read_id:   bus.i_req_read_id,
                      read_cmd:  bus.i_req_read_cmd};
    assign head   = mem[rd_ptr];

    // NOTE: the storage array has no reset; flushing clears pointers and count, so stale entries are never read.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[wr_ptr] <= req_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable gets a default first so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ids_d   = '0;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    ids_d   = head;
                    tmo_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ids_d = ids_q;
                // Valid is checked first so a word in the last permitted cycle completes rather than times out.
                if (bus.i_bus_valid) begin
                    data_d  = bus.i_bus_data;
                    done_d  = 1'b1;
                    ids_d   = '0;
                    pop     = 1'b1;
                    state_d = S_RECOVER;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    ids_d   = '0;
                    pop     = 1'b1;
                    state_d = S_RECOVER;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            ids_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            data_q  <= '0;
        end else begin
            ids_q   <= ids_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            error_q <= error_d;
            data_q  <= data_d;
        end
    end

`ifdef BUS_SEQ_STATS_EN
    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            o_done_count  <= '0;
            o_error_count <= '0;
        end else begin
            if (done_q && (o_done_count != 16'hFFFF))   o_done_count  <= o_done_count + 16'd1;
            if (error_q && (o_error_count != 16'hFFFF)) o_error_count <= o_error_count + 16'd1;
        end
    end
`endif

    assign bus.o_req_ready     = !full;
    assign bus.o_write_id      = ids_q.write_id;
    assign bus.o_write_command = ids_q.write_cmd;
    assign bus.o_read_id       = ids_q.read_id;
    assign bus.o_read_command  = ids_q.read_cmd;
    assign bus.o_done          = done_q;
    assign bus.o_error         = error_q;
    assign bus.o_data          = data_q;
    assign bus.o_busy          = !empty || (state_q != S_IDLE);
endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: request table, scoreboard queue and a bus responder/monitor.
// Build with BUS_SEQ_STATS_EN defined to also check the event counters.
module tb_bus_sequencer;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic i_Clk   = 1'b0;
    logic i_Reset = 1'b0;
    always #5 i_Clk = ~i_Clk;

    bus_sequencer_if #(.DATA_W(DATA_W)) bus ();
`ifdef BUS_SEQ_STATS_EN
    logic [15:0] o_done_count;
    logic [15:0] o_error_count;
`endif

    bus_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .bus          (bus)
`ifdef BUS_SEQ_STATS_EN
        ,
        .o_done_count (o_done_count),
        .o_error_count(o_error_count)
`endif
    );

    // valid_cycle: 1-based ID-visible cycle in which the responder raises valid; 0 = never.
    typedef struct {
        logic [3:0]  wid;
        logic [3:0]  wcmd;
        logic [3:0]  rid;
        logic [3:0]  rcmd;
        int          valid_cycle;
        logic [15:0] data;
    } vec_t;

    typedef struct {
        logic [15:0] ids;
        bit          done;
        logic [15:0] data_out;
        int          hold;
        int          valid_cycle;
        logic [15:0] bus_data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    vec_t        vecs[6];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_data = '0;
    int          exp_done_cnt = 0;
    int          exp_err_cnt  = 0;
    bit          gap_check = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] cur_ids();
        return {bus.o_write_id, bus.o_write_command, bus.o_read_id, bus.o_read_command};
    endfunction

    task automatic push_req(input vec_t v);
        exp_t e;
        int   waited = 0;
        @(negedge i_Clk);
        bus.i_req_valid     = 1'b1;
        bus.i_req_write_id  = v.wid;
        bus.i_req_write_cmd = v.wcmd;
        bus.i_req_read_id   = v.rid;
        bus.i_req_read_cmd  = v.rcmd;
        while (!bus.o_req_ready) begin
            @(negedge i_Clk);
            waited++;
            if (waited > 200) begin
                check("push_ready_timeout", 32'd0, 32'd1);
                bus.i_req_valid = 1'b0;
                return;
            end
        end
        e.ids         = {v.wid, v.wcmd, v.rid, v.rcmd};
        e.valid_cycle = v.valid_cycle;
        e.bus_data    = v.data;
        e.done        = (v.valid_cycle >= 1) && (v.valid_cycle <= TIMEOUT);
        e.hold        = e.done ? v.valid_cycle : TIMEOUT;
        if (e.done) begin
            model_data = v.data;
            exp_done_cnt++;
        end else begin
            exp_err_cnt++;
        end
        e.data_out = model_data;
        exp_q.push_back(e);
        @(posedge i_Clk);
        #1 bus.i_req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (((exp_q.size() != 0) || bus.o_busy) && (n < 400)) begin
            @(negedge i_Clk);
            n++;
        end
        check(name, 32'(n < 400), 32'd1);
    endtask

    // Bus responder and scoreboard monitor, both on the falling edge.
    int          hold     = 0;
    int          zero_run = 0;
    bit          prev_end = 1'b0;
    logic [15:0] seen_ids = '0;
    always @(negedge i_Clk) begin
        if (!gap_check) prev_end = 1'b0;
        if (!i_Reset) begin
            hold            = 0;
            zero_run        = 0;
            prev_end        = 1'b0;
            bus.i_bus_valid = 1'b0;
            bus.i_bus_data  = '0;
        end else begin
            if (bus.o_done || bus.o_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'({bus.o_done, bus.o_error}), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_flag",  32'(bus.o_done),  32'(mon_e.done));
                    check("error_flag", 32'(bus.o_error), 32'(!mon_e.done));
                    check("o_data",     32'(bus.o_data),  32'(mon_e.data_out));
                    check("issued_ids", 32'(seen_ids),    32'(mon_e.ids));
                    check("hold_cycles", 32'(hold),       32'(mon_e.hold));
                end
                hold     = 0;
                prev_end = gap_check;
            end
            if (cur_ids() != 16'h0) begin
                if (hold == 0) begin
                    if (gap_check && prev_end) check("zero_gap", 32'(zero_run), 32'd2);
                    seen_ids = cur_ids();
                end
                hold++;
                zero_run = 0;
                if ((exp_q.size() > 0) && (exp_q[0].valid_cycle == hold)) begin
                    bus.i_bus_valid = 1'b1;
                    bus.i_bus_data  = exp_q[0].bus_data;
                end else begin
                    bus.i_bus_valid = 1'b0;
                    bus.i_bus_data  = 16'($urandom);
                end
            end else begin
                zero_run++;
                bus.i_bus_valid = 1'b0;
                bus.i_bus_data  = 16'($urandom);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_ids"},   32'(cur_ids()),        32'd0);
        check({tag, "_done"},  32'(bus.o_done),       32'd0);
        check({tag, "_error"}, 32'(bus.o_error),      32'd0);
        check({tag, "_data"},  32'(bus.o_data),       32'd0);
        check({tag, "_ready"}, 32'(bus.o_req_ready),  32'd1);
        check({tag, "_busy"},  32'(bus.o_busy),       32'd0);
`ifdef BUS_SEQ_STATS_EN
        check({tag, "_done_count"},  32'(o_done_count),  32'd0);
        check({tag, "_error_count"}, 32'(o_error_count), 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd1,  4'd3,  4'd2,  4'd5,  3, 16'hBEEF};  // completes on 3rd cycle
        vecs[1] = '{4'd7,  4'd0,  4'd0,  4'd0,  0, 16'h0000};  // times out
        vecs[2] = '{4'd3,  4'd1,  4'd4,  4'd2,  8, 16'h1234};  // valid in final permitted cycle
        vecs[3] = '{4'd5,  4'd5,  4'd6,  4'd6,  1, 16'hA5A5};  // valid in first cycle
        vecs[4] = '{4'd0,  4'd0,  4'd9,  4'd1,  0, 16'h0000};  // write_id 0 times out
        vecs[5] = '{4'd15, 4'd15, 4'd15, 4'd15, 2, 16'hFFFF};

        bus.i_req_valid     = 1'b0;
        bus.i_req_write_id  = '0;
        bus.i_req_write_cmd = '0;
        bus.i_req_read_id   = '0;
        bus.i_req_read_cmd  = '0;

        // Power-on reset.
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        check_reset_state("por");
        i_Reset = 1'b1;

        // Table: one request at a time into an idle block, with latency checks.
        for (int i = 0; i < 6; i++) begin
            push_req(vecs[i]);
            @(negedge i_Clk);
            check($sformatf("latency_idle_%0d", i), 32'(cur_ids()), 32'd0);
            @(negedge i_Clk);
            check($sformatf("latency_ids_%0d", i), 32'(cur_ids()),
                  32'({vecs[i].wid, vecs[i].wcmd, vecs[i].rid, vecs[i].rcmd}));
            drain($sformatf("drain_vec_%0d", i));
            check($sformatf("idle_ids_%0d", i), 32'(cur_ids()), 32'd0);
        end

        // Full FIFO with a stalled bus: 4 accepted, push refused across the pop edge, then a 5th.
        gap_check = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req('{4'(i + 1), 4'd8, 4'(i + 2), 4'd9, 0, 16'h0000});
        end
        @(negedge i_Clk);
        check("full_ready", 32'(bus.o_req_ready), 32'd0);
        check("full_busy",  32'(bus.o_busy),      32'd1);
        bus.i_req_valid     = 1'b1;
        bus.i_req_write_id  = 4'hC;
        bus.i_req_write_cmd = 4'hC;
        bus.i_req_read_id   = 4'hC;
        bus.i_req_read_cmd  = 4'hC;
        begin
            int n = 0;
            while (!bus.o_error && (n < 50)) begin
                @(negedge i_Clk);
                n++;
            end
            bus.i_req_valid = 1'b0;
            check("full_pop_seen", 32'(n < 50), 32'd1);
        end
        check("ready_after_pop", 32'(bus.o_req_ready), 32'd1);
        push_req('{4'd6, 4'd8, 4'd7, 4'd9, 2, 16'h5A5A});
        drain("drain_full");
        gap_check = 1'b0;

        // Reset during ISSUE with three queued requests.
        for (int i = 0; i < 3; i++) begin
            push_req('{4'(i + 10), 4'd1, 4'd1, 4'd1, 0, 16'h0000});
        end
        repeat (3) @(negedge i_Clk);
        check("pre_reset_busy", 32'(bus.o_busy), 32'd1);
        i_Reset = 1'b0;
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        check_reset_state("mid_reset");
        exp_q.delete();
        model_data   = '0;
        exp_done_cnt = 0;
        exp_err_cnt  = 0;
        @(negedge i_Clk);
        i_Reset = 1'b1;
        repeat (12) @(negedge i_Clk);
        check("post_reset_ids",  32'(cur_ids()),  32'd0);
        check("post_reset_busy", 32'(bus.o_busy), 32'd0);

        // Queued mix: 3 completions and 2 timeouts, pushed back to back.
        push_req(vecs[0]);
        push_req(vecs[1]);
        push_req(vecs[2]);
        push_req(vecs[4]);
        push_req(vecs[3]);
        drain("drain_mix");
        @(negedge i_Clk);
        check("mix_data", 32'(bus.o_data), 32'(model_data));
`ifdef BUS_SEQ_STATS_EN
        check("done_count",  32'(o_done_count),  32'(exp_done_cnt));
        check("error_count", 32'(o_error_count), 32'(exp_err_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
